// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default character width.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      ARB       = 2'b00,
      ISSUE     = 2'b01,
      WAIT_LOW  = 2'b10,
      WAIT_HIGH = 2'b11
   } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search: first eligible requester at or after ptr, wrapping around.
module rr_select #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      index
);

   localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [2*NUM_REQ-1:0] w_shift;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IW-1:0]        w_offset;
   logic [IW:0]          w_sum;
   logic [IW:0]          w_wrap;

   // Doubling the vector turns the wrap-around search into a plain shift.
   assign w_dbl   = {eligible, eligible};
   assign w_shift = w_dbl >> ptr;
   assign w_rot   = w_shift[NUM_REQ-1:0];
   assign found   = |eligible;

   always_comb begin
      w_offset = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_offset = IW'(k);
         end
      end
   end

   assign w_sum  = {1'b0, ptr} + {1'b0, w_offset};
   assign w_wrap = w_sum - NREQ_W;
   assign index  = (w_sum >= NREQ_W) ? w_wrap[IW-1:0] : w_sum[IW-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one character at a time from several requesters
// into a single UART transmitter, with a sticky flag for a transmitter that never goes busy.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_BITS  = UART_DATA_BITS,
   parameter  int WAIT_LIMIT = 4,
   localparam int IW         = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]           enable_mask,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         tx_valid,
   output logic [DATA_BITS-1:0]         tx_data,
   input  logic                         tx_ready,
   output logic                         busy,
   output logic [IW-1:0]                grant_id,
   output logic                         err
);

   localparam int            CW        = $clog2(WAIT_LIMIT + 1);
   localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);
   localparam logic [CW-1:0] STALL_MAX = CW'(WAIT_LIMIT - 1);

   arb_state_t           r_state;
   arb_state_t           w_state_next;
   logic [IW-1:0]        r_ptr;
   logic [IW-1:0]        r_grant_id;
   logic [DATA_BITS-1:0] r_tx_data;
   logic [CW-1:0]        r_stall_cnt;
   logic                 r_err;

   logic [NUM_REQ-1:0]   w_eligible;
   logic                 w_found;
   logic [IW-1:0]        w_index;
   logic [DATA_BITS-1:0] w_data [NUM_REQ];
   logic                 w_latch;
   logic                 w_advance;
   logic                 w_stall_inc;
   logic                 w_stall_clr;
   logic                 w_set_err;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_data[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
      end
   endgenerate

   assign w_eligible = req_valid & enable_mask;

   rr_select #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_select (
      .eligible (w_eligible),
      .ptr      (r_ptr),
      .found    (w_found),
      .index    (w_index)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      tx_valid     = 1'b0;
      req_ready    = '0;
      w_latch      = 1'b0;
      w_advance    = 1'b0;
      w_stall_inc  = 1'b0;
      w_stall_clr  = 1'b0;
      w_set_err    = 1'b0;
      case (r_state)
         ARB: begin
            if (tx_ready && w_found) begin
               w_latch      = 1'b1;
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            tx_valid              = 1'b1;
            req_ready[r_grant_id] = 1'b1;
            w_advance             = 1'b1;
            w_stall_clr           = 1'b1;
            w_state_next          = WAIT_LOW;
         end
         WAIT_LOW: begin
            // ready staying high for the first cycle here is normal; only a long stall is an error
            if (!tx_ready) begin
               w_stall_clr  = 1'b1;
               w_state_next = WAIT_HIGH;
            end else if (r_stall_cnt == STALL_MAX) begin
               w_set_err    = 1'b1;
               w_stall_clr  = 1'b1;
               w_state_next = ARB;
            end else begin
               w_stall_inc = 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (tx_ready) begin
               w_state_next = ARB;
            end
         end
         default: w_state_next = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_grant_id  <= '0;
         r_tx_data   <= '0;
         r_stall_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_latch) begin
            r_tx_data  <= w_data[w_index];
            r_grant_id <= w_index;
         end
         if (w_advance) begin
            r_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
         end
         if (w_stall_clr) begin
            r_stall_cnt <= '0;
         end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_set_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign tx_data  = r_tx_data;
   assign grant_id = r_grant_id;
   assign err      = r_err;
   assign busy     = (r_state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, grant scoreboard, vector table and corner sequences.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N*DB-1:0] req_data = '0;
   logic [N-1:0]  enable_mask = '1;
   logic [N-1:0]  req_ready;
   logic          tx_valid;
   logic [DB-1:0] tx_data;
   logic          tx_ready = 1'b0;
   logic          busy;
   logic [1:0]    grant_id;
   logic          err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [3:0] rv;
      logic [3:0] em;
      bit         found;
      int         id;
   } vec_t;
   vec_t tbl[14];

   int sent[N];
   int exp_k[N];

   bit model_on  = 1'b0;
   int frame_len = 20;
   int mcnt      = 0;
   bit mhold     = 1'b0;
   bit macc      = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ    (N),
      .DATA_BITS  (DB),
      .WAIT_LIMIT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .enable_mask (enable_mask),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .grant_id    (grant_id),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ch(input int i, input int k);
      return 8'(i * 64 + k * 7 + 1);
   endfunction

   // Transmitter: ready stays high one cycle after acceptance, then low for a frame.
   always begin
      @(negedge clk);
      macc = model_on && tx_valid && tx_ready;
      @(posedge clk);
      #1;
      if (model_on) begin
         if (macc) begin
            mhold = 1'b1;
         end else if (mhold) begin
            mhold    = 1'b0;
            tx_ready = 1'b0;
            mcnt     = frame_len;
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) tx_ready = 1'b1;
         end
      end
   end

   // Scoreboard: every tx_valid pulse must match the next expected grant.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (tx_valid) begin
            $display("[TB] grant id=%0d data=%02h req_ready=%b", grant_id, tx_data, req_ready);
            if (!tx_ready) begin
               tests++;
               fails++;
               $display("FAIL tx_valid_while_busy: tx_ready=%0b, required 1", tx_ready);
            end
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_grant: got id %0d, required no grant", grant_id);
            end else begin
               e = sb_q.pop_front();
               chk("grant_id", grant_id, e.id);
               chk("tx_data", tx_data, e.data);
               chk("req_ready", req_ready, 32'(1 << e.id));
               if (sb_q.size() == 0) begin
                  req_valid = '0;
               end else begin
                  sent[e.id]++;
                  req_data[e.id*DB +: DB] = ch(e.id, sent[e.id]);
               end
            end
         end else if (req_ready != '0) begin
            tests++;
            fails++;
            $display("FAIL stray_req_ready: got %b, required 0000", req_ready);
         end
      end
   end

   task automatic model_start();
      tx_ready = 1'b1;
      mhold    = 1'b0;
      mcnt     = 0;
      model_on = 1'b1;
   endtask

   task automatic model_stop(input logic rdy);
      model_on = 1'b0;
      tx_ready = rdy;
   endtask

   task automatic wait_sb(input string name, input int max);
      int n = 0;
      while (sb_q.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL %s: timeout with %0d grants pending, required 0", name, sb_q.size());
         sb_q.delete();
         req_valid = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (!(busy == 1'b0 && tx_ready == 1'b1) && n < max) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL %s: idle timeout, busy=%0b required 0", name, busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_grant_id"}, grant_id, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
   endtask

   initial begin
      int n;
      tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 1};
      tbl[1]  = '{4'b1111, 4'b1010, 1'b1, 3};
      tbl[2]  = '{4'b1111, 4'b1010, 1'b1, 1};
      tbl[3]  = '{4'b1111, 4'b1010, 1'b1, 3};
      tbl[4]  = '{4'b0101, 4'b1010, 1'b0, 0};
      tbl[5]  = '{4'b0000, 4'b1111, 1'b0, 0};
      tbl[6]  = '{4'b0100, 4'b1111, 1'b1, 2};
      tbl[7]  = '{4'b0010, 4'b1111, 1'b1, 1};
      tbl[8]  = '{4'b1100, 4'b1111, 1'b1, 2};
      tbl[9]  = '{4'b1001, 4'b1111, 1'b1, 3};
      tbl[10] = '{4'b1001, 4'b1111, 1'b1, 0};
      tbl[11] = '{4'b1000, 4'b1111, 1'b1, 3};
      tbl[12] = '{4'b1000, 4'b1111, 1'b1, 3};
      tbl[13] = '{4'b0001, 4'b0000, 1'b0, 0};

      // Reset and idle with the transmitter not yet ready
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");
      req_valid = 4'b0001;
      req_data[7:0] = 8'hA5;
      repeat (4) @(negedge clk);
      chk("idle_not_ready_busy", busy, 0);
      @(posedge clk);
      #1;
      sb_q.push_back('{0, 8'hA5});
      model_start();
      @(negedge clk);
      chk("latency_early", tx_valid, 0);
      @(negedge clk);
      chk("latency_one_cycle", tx_valid, 1);
      wait_sb("first_grant", 20);
      wait_idle("first_idle", 100);

      // Table of single-character arbitrations
      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < N; i++) req_data[i*DB +: DB] = 8'($urandom);
         enable_mask = tbl[t].em;
         if (tbl[t].found) sb_q.push_back('{tbl[t].id, req_data[tbl[t].id*DB +: DB]});
         req_valid = tbl[t].rv;
         $display("[TB] vector %0d rv=%b em=%b expect found=%0b id=%0d",
                  t, tbl[t].rv, tbl[t].em, tbl[t].found, tbl[t].id);
         if (tbl[t].found) begin
            wait_sb("vector_grant", 30);
            wait_idle("vector_idle", 100);
         end else begin
            repeat (8) @(negedge clk);
            chk("vector_no_grant_busy", busy, 0);
            @(posedge clk);
            #1;
            req_valid = '0;
         end
      end

      // Fairness with all requesters streaming over long frames
      frame_len = 160;
      for (int i = 0; i < N; i++) begin
         sent[i]  = 0;
         exp_k[i] = 0;
         req_data[i*DB +: DB] = ch(i, 0);
      end
      for (int g = 0; g < 6; g++) begin
         sb_q.push_back('{g % N, ch(g % N, exp_k[g % N])});
         exp_k[g % N]++;
      end
      enable_mask = 4'b1111;
      req_valid   = 4'b1111;
      wait_sb("fairness", 2500);
      wait_idle("fairness_idle", 400);
      frame_len = 20;

      // Stall: transmitter never drops ready
      model_stop(1'b1);
      sb_q.push_back('{0, 8'h3C});
      req_data[7:0] = 8'h3C;
      req_valid = 4'b0001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_valid && n < 20);
      chk("stall_issue_seen", tx_valid, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("stall_wait_low_busy", busy, 1);
         chk("stall_wait_low_err", err, 0);
      end
      @(negedge clk);
      chk("stall_err_set", err, 1);
      chk("stall_back_in_arb", busy, 0);
      repeat (5) @(negedge clk);
      chk("stall_err_sticky", err, 1);
      @(posedge clk);
      #1;
      model_start();
      sb_q.push_back('{1, 8'h77});
      req_data[15:8] = 8'h77;
      req_valid = 4'b0010;
      wait_sb("after_stall_grant", 30);
      wait_idle("after_stall_idle", 100);
      chk("after_stall_err_kept", err, 1);

      // Reset in the middle of a frame
      sb_q.push_back('{2, 8'hC3});
      req_data[23:16] = 8'hC3;
      req_valid = 4'b0100;
      wait_sb("midframe_grant", 30);
      n = 0;
      while (!(tx_ready == 1'b0 && busy == 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("midframe_in_wait_high", busy, 1);
      @(posedge clk);
      #1;
      model_stop(1'b1);
      rst = 1'b1;
      req_valid   = 4'b1111;
      enable_mask = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i*DB +: DB] = ch(i, 9);
      sb_q.push_back('{0, ch(0, 9)});
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_start();
      @(negedge clk);
      chk_reset_outputs("midframe_reset");
      wait_sb("post_reset_grant", 30);
      wait_idle("post_reset_idle", 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
